// File: rtl/serial_crc_pkg.sv
// Shared types and defaults for the bit-serial CRC generator.
// Default build omits the done strobe; define SERIAL_CRC_DONE_EN to add it.
package serial_crc_pkg;

  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_CRC_W  = 9;
  localparam logic [8:0]  DEF_POLY   = 9'h011;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    DONE
  } state_e;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << w) < n) w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit Galois LFSR update: shifts in one message bit against polynomial i_poly.
module crc_lfsr_step #(
  parameter int unsigned CRC_W = 9
) (
  input  logic [CRC_W-1:0] i_lfsr,
  input  logic             i_bit,
  input  logic [CRC_W-1:0] i_poly,
  output logic [CRC_W-1:0] o_lfsr
);

  logic w_fb;

  assign w_fb   = i_bit ^ i_lfsr[CRC_W-1];
  assign o_lfsr = {i_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? i_poly : '0);

endmodule

// File: rtl/serial_crc.sv
// Free-running bit-serial CRC frame engine: LOAD, DATA_W SHIFT cycles, DONE.
// Optional done strobe enabled by defining SERIAL_CRC_DONE_EN.
module serial_crc
  import serial_crc_pkg::*;
#(
  parameter int unsigned      DATA_W = DEF_DATA_W,
  parameter int unsigned      CRC_W  = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(DEF_POLY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  data_out
`ifdef SERIAL_CRC_DONE_EN
  ,
  output logic              done
`endif
);

  localparam int unsigned CNT_W = clog2(DATA_W);

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_msg;
  logic [CRC_W-1:0]    r_lfsr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CRC_W-1:0]    r_data_out;
  logic [CRC_W-1:0]    w_lfsr_next;
  logic                w_last_bit;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  crc_lfsr_step #(
    .CRC_W (CRC_W)
  ) u_step (
    .i_lfsr (r_lfsr),
    .i_bit  (r_msg[DATA_W-1]),
    .i_poly (POLY),
    .o_lfsr (w_lfsr_next)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      LOAD:    w_state_next = SHIFT;
      SHIFT:   if (w_last_bit) w_state_next = DONE;
      DONE:    w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= LOAD;
      r_msg      <= '0;
      r_lfsr     <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        LOAD: begin
          r_msg  <= data_in;
          r_lfsr <= '0;
          r_cnt  <= '0;
        end
        SHIFT: begin
          r_lfsr <= w_lfsr_next;
          r_msg  <= {r_msg[DATA_W-2:0], 1'b0};
          r_cnt  <= r_cnt + 1'b1;
        end
        DONE:    r_data_out <= r_lfsr;
        default: ;
      endcase
    end
  end

  assign data_out = r_data_out;

`ifdef SERIAL_CRC_DONE_EN
  // High during the cycle that follows each data_out update.
  logic r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= (r_state == DONE);
  end

  assign done = r_done;
`endif

endmodule

// File: tb/tb_serial_crc.sv
// Randomized self-checking bench for serial_crc against a polynomial-division model.
module tb_serial_crc;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CRC_W  = 9;
  localparam logic [8:0]  POLY   = 9'h011;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic [CRC_W-1:0]  data_out;
`ifdef SERIAL_CRC_DONE_EN
  logic              done;
`endif

  int checks;
  int failures;
  logic [CRC_W-1:0] prev_crc;

  serial_crc #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef SERIAL_CRC_DONE_EN
    ,
    .done     (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M(x)*x^9 mod G(x) by long division over GF(2).
  function automatic logic [CRC_W-1:0] crc_ref(input logic [DATA_W-1:0] m);
    logic [18:0] rem;
    logic [18:0] g;
    g   = {10'b0, 1'b1, POLY} ;
    rem = {m, 9'b0};
    for (int i = 18; i >= 9; i--) begin
      if (rem[i]) rem = rem ^ (g << (i - 9));
    end
    return rem[CRC_W-1:0];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL reset_data_out: got %h want 000", data_out);
    end
`ifdef SERIAL_CRC_DONE_EN
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", done);
    end
`endif
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    prev_crc = '0;
  endtask

  // One 12-edge frame starting at the next rising edge (the LOAD edge).
  task automatic run_frame(input logic [DATA_W-1:0] word, input logic [CRC_W-1:0] want,
                           input bit junk, input logic [DATA_W-1:0] after_load);
    data_in = word;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) data_in = junk ? DATA_W'($urandom) : after_load;
      else if (junk) data_in = DATA_W'($urandom);
      checks++;
      if (e < 12 && data_out !== prev_crc) begin
        failures++;
        $display("FAIL hold edge%0d: got %h want %h", e, data_out, prev_crc);
      end else if (e == 12 && data_out !== want) begin
        failures++;
        $display("FAIL crc word=%h: got %h want %h", word, data_out, want);
      end
`ifdef SERIAL_CRC_DONE_EN
      checks++;
      if (done !== (e == 12)) begin
        failures++;
        $display("FAIL done edge%0d: got %b want %b", e, done, (e == 12));
      end
`endif
    end
    prev_crc = want;
  endtask

  task automatic test_reset();
    apply_reset();
    run_frame(10'b1100000011, 9'h0BA, 1'b0, 10'b1100000011);
  endtask

  task automatic test_hold();
    apply_reset();
    run_frame(10'b1011001011, 9'h11C, 1'b0, 10'b1011001011);
    run_frame(10'b1011001011, 9'h11C, 1'b0, 10'b1011001011);
  endtask

  task automatic test_corners();
    run_frame(10'h000, 9'h000, 1'b0, 10'h000);
    run_frame(10'h3FF, crc_ref(10'h3FF), 1'b0, 10'h3FF);
  endtask

  task automatic test_input_change();
    apply_reset();
    run_frame(10'b1100000011, 9'h0BA, 1'b0, 10'b1011001011);
    run_frame(10'b1011001011, 9'h11C, 1'b0, 10'b1011001011);
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    run_frame(10'b1011001011, 9'h11C, 1'b0, 10'b1100000011);
    data_in = 10'b1100000011;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL midframe_reset: got %h want 000", data_out);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    prev_crc = '0;
    run_frame(10'b1100000011, 9'h0BA, 1'b0, 10'b1100000011);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w;
    for (int f = 0; f < 20; f++) begin
      w = DATA_W'($urandom);
      run_frame(w, crc_ref(w), 1'b1, '0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_crc = '0;
    reset    = 1'b1;
    data_in  = '0;
    test_reset();
    test_hold();
    test_corners();
    test_input_change();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
